dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port: the slave end of the core's address / writedata / memwrite / readdata interface.
- Adds a req/ready handshake with a programmable wait-state count, so the core can be run against slow memory models.
- Implements word, halfword and byte writes with little-endian lane placement. Reads return aligned words; the core's datapath does lb/lbu/lh extraction.
- Sits between the core (or a bus adapter) and nothing else: it owns the storage array.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of 2, ≥4).
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..255).
- INIT_FILE, "", hex file loaded with $readmemh at elaboration if non-empty.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- addr  in  32  byte address (aluout from core).
- memwrite  in  2  op: 00 read, 01 word write, 10 halfword write, 11 byte write.
- writedata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- readdata  out  32  word at addr[..:2]; post-write value for writes.
- ready  out  1  one-cycle response pulse.
- err  out  1  valid with ready: misaligned or out-of-range access.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; ready=0, err=0, readdata=0, wait counter=0; captured request cleared.
  - Array contents are not reset.
  - Reset mid-operation abandons the request; an uncommitted write is never performed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req=1, capture addr/memwrite/writedata. Go to BUSY with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to DONE.
  - BUSY: decrement cnt; when cnt==0, go to DONE.
  - DONE: ready=1 for exactly this cycle, then go to IDLE.
- Latency: ready is high exactly WAIT_CYCLES+1 edges after the accepting edge.
  - WAIT_CYCLES=0 gives ready in the cycle after acceptance.
  - Minimum request spacing is WAIT_CYCLES+2 cycles.
- req in BUSY or DONE is ignored (no queue); the core must re-present it in IDLE.
- Input changes after acceptance have no effect; the captured copy is used.
- Write commit and readdata/err update all occur on the edge entering DONE, so they are valid while ready=1.
- readdata and err hold their values until the next response (or reset).
- Index = addr[log2(DEPTH)+1:2].
  - Out of range if addr ≥ DEPTH*4: err=1, readdata=0, no write.
- Alignment:
  - Word write requires addr[1:0]==0.
  - Half write requires addr[0]==0.
  - Byte writes are always aligned.
  - On violation: err=1, no write, readdata = current word.
  - Reads never flag misalignment; addr[1:0] is ignored.
- Lane placement (little-endian):
  - Byte: addr[1:0]=k writes bits [8k+7:8k] from writedata[7:0].
  - Half: addr[1]=0 writes [15:0], addr[1]=1 writes [31:16], from writedata[15:0].
  - Unwritten lanes are preserved.
- Read-after-write to the same word in consecutive transactions must return the new data (no bypass hazards).

Test Plan:
- Reset with WAIT_CYCLES=2, then read addr 0x0 → ready pulses exactly 3 edges after acceptance; ready, err and readdata are 0 before the pulse.
- Word write 0xDEADBEEF @0x10, then read 0x10 → readdata=0xDEADBEEF, err=0. Second readdata also 0xDEADBEEF on the write response.
- Byte write 0xAA @0x13 and half write 0x1234 @0x10 over 0x00000000 → read 0x10 returns 0xAA001234.
- Word write @0x12, half write @0x11, and read @DEPTH*4 → err=1 each time; memory unchanged; out-of-range readdata=0.
- req held high continuously with WAIT_CYCLES=0 → one ready every 2 cycles. Changing writedata during BUSY (WAIT_CYCLES=3) does not alter the stored value.
- reset=0 during BUSY of a word write 0x55 @0x20 (prior value 0x11) → ready stays 0; subsequent read @0x20 returns 0x11.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with req/ready handshake and wait states.
// Ports: clk, reset (sync, low), req/addr/memwrite/writedata in; readdata/ready/err out.
module dmem_responder #(
  parameter int    DEPTH       = 64,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] WLOAD =
    (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam bit NOWAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] c_addr;
  logic [31:0] c_wd;
  logic [1:0]  c_op;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic [31:0]   a;
  logic [31:0]   wd;
  logic [1:0]    op;
  logic [AW-1:0] idx;
  logic          oor;
  logic          mis;
  logic [3:0]    be;
  logic [31:0]   rep;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic          we;

  assign accept = (state == IDLE) && req;
  assign commit = (accept && NOWAIT) ||
                  ((state == BUSY) && (cnt == 8'd0));

  assign a  = (state == IDLE) ? addr      : c_addr;
  assign wd = (state == IDLE) ? writedata : c_wd;
  assign op = (state == IDLE) ? memwrite  : c_op;

  assign idx = a[AW+1:2];
  assign oor = |a[31:AW+2];
  assign cur = mem[idx];

  always_comb begin
    mis = 1'b0;
    be  = 4'b0000;
    rep = wd;
    unique case (op)
      2'b01: begin
        mis = (a[1:0] != 2'b00);
        be  = 4'b1111;
        rep = wd;
      end
      2'b10: begin
        mis = a[0];
        be  = a[1] ? 4'b1100 : 4'b0011;
        rep = {2{wd[15:0]}};
      end
      2'b11: begin
        be  = 4'b0001 << a[1:0];
        rep = {4{wd[7:0]}};
      end
      default: begin
        be  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end
  end

  assign we = commit && !oor && !mis && (be != 4'b0000);

  always_ff @(posedge clk) begin
    if (reset && we) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ready    <= 1'b0;
      err      <= 1'b0;
      readdata <= 32'd0;
      c_addr   <= 32'd0;
      c_wd     <= 32'd0;
      c_op     <= 2'b00;
    end else begin
      ready <= 1'b0;
      if (commit) begin
        err <= oor | mis;
        if (oor)
          readdata <= 32'd0;
        else if (mis)
          readdata <= cur;
        else
          readdata <= merged;
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            c_addr <= addr;
            c_wd   <= writedata;
            c_op   <= memwrite;
            if (NOWAIT) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= WLOAD;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state <= DONE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
